// File: rtl/gauss5_share_sched_pkg.sv
// gauss_share_pkg: shared types and constants for the gauss5 sharing scheduler.
package gauss_share_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_WIN,
        S_ISSUE,
        S_WAIT_RES,
        S_EMIT
    } state_t;
    localparam logic [1:0] XX = 2'd0;
    localparam logic [1:0] XY = 2'd1;
    localparam logic [1:0] YY = 2'd2;
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_STRAY    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;
    function automatic int gw(input int dw);
        return dw + 9;
    endfunction
endpackage

// File: rtl/gauss5_share_sched_if.sv
// gauss5_share_sched_if: upstream window, gauss5 and downstream triple buses.
interface gauss5_share_sched_if #(
    parameter int DATA_WIDTH = 14
);
    localparam int XW = DATA_WIDTH + 1;
    localparam int GW = gauss_share_pkg::gw(DATA_WIDTH);
    logic [25*DATA_WIDTH-1:0] in_window_value_xx;
    logic [25*XW-1:0]         in_window_value_xy;
    logic [25*DATA_WIDTH-1:0] in_window_value_yy;
    logic [15:0]              in_window_addr;
    logic                     in_window_valid;
    logic                     window_req;
    logic [25*XW-1:0]         g_window_value;
    logic [15:0]              g_window_addr;
    logic                     g_window_valid;
    logic                     g_window_req;
    logic [GW-1:0]            g_event_value;
    logic [15:0]              g_event_addr;
    logic                     g_event_valid;
    logic                     g_ready;
    logic [GW-1:0]            out_value_xx;
    logic [GW-1:0]            out_value_xy;
    logic [GW-1:0]            out_value_yy;
    logic [15:0]              out_addr;
    logic                     out_valid;
    logic                     out_ready;
    logic                     err;
    logic [1:0]               err_code;
    modport slave (
        input  in_window_value_xx, in_window_value_xy, in_window_value_yy,
        input  in_window_addr, in_window_valid,
        output window_req,
        output g_window_value, g_window_addr, g_window_valid,
        input  g_window_req, g_event_value, g_event_addr, g_event_valid,
        output g_ready,
        output out_value_xx, out_value_xy, out_value_yy, out_addr, out_valid,
        input  out_ready,
        output err, err_code
    );
    modport master (
        output in_window_value_xx, in_window_value_xy, in_window_value_yy,
        output in_window_addr, in_window_valid,
        input  window_req,
        input  g_window_value, g_window_addr, g_window_valid,
        output g_window_req, g_event_value, g_event_addr, g_event_valid,
        input  g_ready,
        input  out_value_xx, out_value_xy, out_value_yy, out_addr, out_valid,
        output out_ready,
        input  err, err_code
    );
endinterface

// File: rtl/gauss5_share_sched.sv
// gauss5_share_sched: time-multiplexes one gauss5 kernel over the xx/xy/yy
// structure-tensor windows and re-assembles the smoothed triple.
module gauss5_share_sched
    import gauss_share_pkg::*;
#(
    parameter int DATA_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    gauss5_share_sched_if.slave bus
);
    localparam int XW  = DATA_WIDTH + 1;
    localparam int GW  = gw(DATA_WIDTH);
    localparam int WW  = 25 * XW;
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                   state_q, state_d;
    logic [1:0]               ch_q, ch_d;
    logic                     g_pend_q, g_pend_d;
    logic [WDW-1:0]           wd_q, wd_d;
    logic [25*DATA_WIDTH-1:0] win_xx_q, win_xx_d, win_yy_q, win_yy_d;
    logic [WW-1:0]            win_xy_q, win_xy_d, ext_xx, ext_yy;
    logic [WW-1:0]            g_win_q, g_win_d;
    logic [15:0]              addr_q, addr_d;
    logic [2:0][GW-1:0]       res_q, res_d;
    logic                     window_req_q, window_req_d;
    logic                     g_valid_q, g_valid_d;
    logic                     g_ready_q, g_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     err_q, err_d;
    logic [1:0]               err_code_q, err_code_d;
    logic                     load, issue, capture, mismatch, timeout, stray;

    assign load     = state_q == S_WAIT_WIN && bus.in_window_valid;
    assign issue    = state_q == S_ISSUE && g_pend_q;
    assign capture  = state_q == S_WAIT_RES && bus.g_event_valid;
    assign mismatch = capture && bus.g_event_addr != addr_q;
    assign timeout  = state_q == S_WAIT_RES && !bus.g_event_valid && wd_q == WDW'(TIMEOUT_CYCLES - 1);
    assign stray    = state_q != S_WAIT_RES && bus.g_event_valid;

    // xx/yy are unsigned, so they widen to the signed xy pixel width with a zero MSB
    for (genvar i = 0; i < 25; i++) begin : g_ext
        assign ext_xx[i*XW +: XW] = {1'b0, win_xx_q[i*DATA_WIDTH +: DATA_WIDTH]};
        assign ext_yy[i*XW +: XW] = {1'b0, win_yy_q[i*DATA_WIDTH +: DATA_WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_REQ;
            S_REQ:      state_d = S_WAIT_WIN;
            S_WAIT_WIN: state_d = bus.in_window_valid ? S_ISSUE : S_WAIT_WIN;
            S_ISSUE:    state_d = g_pend_q ? S_WAIT_RES : S_ISSUE;
            S_WAIT_RES: state_d = capture ? (ch_q == YY ? S_EMIT : S_ISSUE) : timeout ? S_IDLE : S_WAIT_RES;
            S_EMIT:     state_d = bus.out_ready ? S_IDLE : S_EMIT;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ch_d     = state_q == S_WAIT_WIN ? XX : (capture && ch_q != YY) ? ch_q + 2'd1 : ch_q;
        g_pend_d = bus.g_window_req | (g_pend_q & ~issue);
        wd_d     = issue ? '0 : state_q == S_WAIT_RES ? wd_q + WDW'(1) : wd_q;
        win_xx_d = load ? bus.in_window_value_xx : win_xx_q;
        win_xy_d = load ? bus.in_window_value_xy : win_xy_q;
        win_yy_d = load ? bus.in_window_value_yy : win_yy_q;
        addr_d   = load ? bus.in_window_addr : addr_q;
        g_win_d  = issue ? (ch_q == XX ? ext_xx : ch_q == XY ? win_xy_q : ext_yy) : g_win_q;
        res_d    = res_q;
        for (int k = 0; k < 3; k++)
            res_d[k] = (capture && ch_q == 2'(k)) ? bus.g_event_value : res_q[k];
        window_req_d = state_d == S_REQ;
        g_valid_d    = issue;
        g_ready_d    = state_d == S_WAIT_RES;
        out_valid_d  = state_d == S_EMIT;
        err_d        = err_q | mismatch | stray | timeout;
        err_code_d   = err_q ? err_code_q : mismatch ? ERR_MISMATCH : stray ? ERR_STRAY :
                       timeout ? ERR_TIMEOUT : ERR_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q         <= XX;
            g_pend_q     <= 1'b0;
            wd_q         <= '0;
            win_xx_q     <= '0;
            win_xy_q     <= '0;
            win_yy_q     <= '0;
            addr_q       <= '0;
            g_win_q      <= '0;
            res_q        <= '0;
            window_req_q <= 1'b0;
            g_valid_q    <= 1'b0;
            g_ready_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            ch_q         <= ch_d;
            g_pend_q     <= g_pend_d;
            wd_q         <= wd_d;
            win_xx_q     <= win_xx_d;
            win_xy_q     <= win_xy_d;
            win_yy_q     <= win_yy_d;
            addr_q       <= addr_d;
            g_win_q      <= g_win_d;
            res_q        <= res_d;
            window_req_q <= window_req_d;
            g_valid_q    <= g_valid_d;
            g_ready_q    <= g_ready_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.window_req     = window_req_q;
    assign bus.g_window_value = g_win_q;
    assign bus.g_window_addr  = addr_q;
    assign bus.g_window_valid = g_valid_q;
    assign bus.g_ready        = g_ready_q;
    assign bus.out_value_xx   = res_q[0];
    assign bus.out_value_xy   = res_q[1];
    assign bus.out_value_yy   = res_q[2];
    assign bus.out_addr       = addr_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.err            = err_q;
    assign bus.err_code       = err_code_q;
endmodule

// File: tb/tb_gauss5_share_sched.sv
// tb_gauss5_share_sched: directed scenarios against a hand-driven gauss5 with 4-cycle latency.
module tb_gauss5_share_sched;
    localparam int DW = 14;
    localparam int XW = 15;
    localparam int GW = 23;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [25*XW-1:0] exp_xx, exp_xy, exp_yy;

    gauss5_share_sched_if #(.DATA_WIDTH(DW)) bus ();
    gauss5_share_sched #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_window_value_xx = {25{14'h3FFF}};
        bus.in_window_value_xy = {25{15'h7FFB}};
        bus.in_window_value_yy = {25{14'h0123}};
        bus.in_window_addr = 16'h0;
        bus.in_window_valid = 1'b0;
        bus.g_window_req = 1'b0;
        bus.g_event_value = '0;
        bus.g_event_addr = 16'h0;
        bus.g_event_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.window_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // called while window_req is visible (REQ); presents the window during WAIT_WIN
    task automatic send_window(input logic [15:0] a);
        tick();
        bus.in_window_valid = 1'b1;
        bus.in_window_addr = a;
        bus.g_window_req = 1'b1;
        tick();
        bus.in_window_valid = 1'b0;
        bus.g_window_req = 1'b0;
    endtask

    task automatic serve(input logic [GW-1:0] v, input logic [15:0] a, input bit req, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.g_window_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            repeat (3) tick();
            bus.g_event_valid = 1'b1;
            bus.g_event_value = v;
            bus.g_event_addr = a;
            bus.g_window_req = req;
            tick();
            bus.g_event_valid = 1'b0;
            bus.g_window_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.window_req, bus.g_window_valid, bus.g_ready, bus.out_valid, bus.err, bus.err_code,
             bus.out_value_xx, bus.out_value_xy, bus.out_value_yy, bus.out_addr,
             bus.g_window_value, bus.g_window_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b gv=%b rdy=%b ov=%b err=%b code=%0d want all zero",
                     bus.window_req, bus.g_window_valid, bus.g_ready, bus.out_valid, bus.err, bus.err_code);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.window_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_req got %b want 1", bus.window_req);
        end
        tick();
        checks++;
        if (bus.window_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_one_cycle got %b want 0", bus.window_req);
        end
    endtask

    task automatic test_nominal();
        bit ok, all_ok;
        do_reset();
        wait_req(ok);
        all_ok = ok;
        send_window(16'h1234);
        tick();
        checks++;
        if ({bus.g_window_valid, bus.g_ready, bus.g_window_addr} !== {1'b1, 1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL nominal_issue got gv=%b rdy=%b addr=%h want 1 1 1234",
                     bus.g_window_valid, bus.g_ready, bus.g_window_addr);
        end
        checks++;
        if (bus.g_window_value !== exp_xx) begin
            errors++;
            $display("FAIL nominal_xx_window got %h want %h", bus.g_window_value[29:0], exp_xx[29:0]);
        end
        serve(23'd100, 16'h1234, 1'b1, ok);
        all_ok &= ok;
        serve(23'h7FFFFB, 16'h1234, 1'b1, ok);
        all_ok &= ok;
        serve(23'd200, 16'h1234, 1'b1, ok);
        all_ok &= ok;
        checks++;
        if (!all_ok) begin
            errors++;
            $display("FAIL nominal_handshake got stalled want req and three issues");
        end
        checks++;
        if ({bus.out_valid, bus.out_value_xx, bus.out_value_xy, bus.out_value_yy, bus.out_addr, bus.err} !==
            {1'b1, 23'd100, 23'h7FFFFB, 23'd200, 16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL nominal_triple got ov=%b xx=%0d xy=%h yy=%0d addr=%h err=%b want 1 100 7ffffb 200 1234 0",
                     bus.out_valid, bus.out_value_xx, bus.out_value_xy, bus.out_value_yy, bus.out_addr, bus.err);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nominal_accept got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_stall();
        bit ok, all_ok;
        int bad;
        do_reset();
        wait_req(ok);
        all_ok = ok;
        send_window(16'h0042);
        serve(23'd7, 16'h0042, 1'b1, ok);
        all_ok &= ok;
        serve(23'd8, 16'h0042, 1'b1, ok);
        all_ok &= ok;
        serve(23'd9, 16'h0042, 1'b1, ok);
        all_ok &= ok;
        checks++;
        if (!all_ok) begin
            errors++;
            $display("FAIL stall_handshake got stalled want three issues");
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({bus.out_valid, bus.out_value_xx, bus.out_value_xy, bus.out_value_yy, bus.out_addr} !==
                {1'b1, 23'd7, 23'd8, 23'd9, 16'h0042})
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable cycles want 0", bad);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.out_valid, bus.window_req} !== 2'b00) begin
            errors++;
            $display("FAIL stall_accept got ov=%b req=%b want 0 0", bus.out_valid, bus.window_req);
        end
        tick();
        checks++;
        if (bus.window_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_next_req got %b want 1", bus.window_req);
        end
    endtask

    task automatic test_mismatch();
        bit ok, all_ok;
        do_reset();
        wait_req(ok);
        all_ok = ok;
        send_window(16'h1234);
        serve(23'd1, 16'h1234, 1'b1, ok);
        all_ok &= ok;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_clean_xx got %b want 0", bus.err);
        end
        serve(23'd2, 16'h1235, 1'b1, ok);
        all_ok &= ok;
        checks++;
        if ({bus.err, bus.err_code} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL mismatch_err got err=%b code=%0d want 1 1", bus.err, bus.err_code);
        end
        serve(23'd3, 16'h1234, 1'b1, ok);
        all_ok &= ok;
        checks++;
        if ({all_ok, bus.out_valid, bus.out_value_xx, bus.out_value_xy, bus.out_value_yy} !==
            {1'b1, 1'b1, 23'd1, 23'd2, 23'd3}) begin
            errors++;
            $display("FAIL mismatch_emit got ok=%b ov=%b xx=%0d xy=%0d yy=%0d want 1 1 1 2 3",
                     all_ok, bus.out_valid, bus.out_value_xx, bus.out_value_xy, bus.out_value_yy);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int ov;
        do_reset();
        wait_req(ok);
        send_window(16'h0100);
        tick();
        checks++;
        if ({ok, bus.g_window_valid} !== 2'b11) begin
            errors++;
            $display("FAIL timeout_issue got ok=%b gv=%b want 1 1", ok, bus.g_window_valid);
        end
        ov = 0;
        repeat (7) begin
            tick();
            ov += int'(bus.out_valid);
        end
        checks++;
        if ({bus.err, bus.g_ready} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_early got err=%b rdy=%b want 0 1", bus.err, bus.g_ready);
        end
        tick();
        ov += int'(bus.out_valid);
        checks++;
        if ({bus.err, bus.err_code, bus.g_ready, ov != 0} !== {1'b1, 2'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_err got err=%b code=%0d rdy=%b ov_cycles=%0d want 1 3 0 0",
                     bus.err, bus.err_code, bus.g_ready, ov);
        end
        tick();
        checks++;
        if ({bus.window_req, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_restart got req=%b ov=%b want 1 0", bus.window_req, bus.out_valid);
        end
    endtask

    task automatic test_stray();
        bit ok;
        do_reset();
        wait_req(ok);
        bus.in_window_valid = 1'b1;
        tick();
        bus.in_window_valid = 1'b0;
        checks++;
        if ({ok, bus.err} !== 2'b10) begin
            errors++;
            $display("FAIL ignored_window got ok=%b err=%b want 1 0", ok, bus.err);
        end
        bus.g_event_valid = 1'b1;
        tick();
        bus.g_event_valid = 1'b0;
        checks++;
        if ({bus.err, bus.err_code} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL stray_err got err=%b code=%0d want 1 2", bus.err, bus.err_code);
        end
    endtask

    task automatic test_coincide();
        bit ok, all_ok;
        do_reset();
        wait_req(ok);
        all_ok = ok;
        send_window(16'h0777);
        serve(23'd11, 16'h0777, 1'b1, ok);
        all_ok &= ok;
        bus.g_window_req = 1'b1;
        tick();
        bus.g_window_req = 1'b0;
        checks++;
        if ({bus.g_window_valid, bus.g_window_value} !== {1'b1, exp_xy}) begin
            errors++;
            $display("FAIL coincide_xy_issue got gv=%b px0=%h want 1 %h",
                     bus.g_window_valid, bus.g_window_value[14:0], exp_xy[14:0]);
        end
        serve(23'd12, 16'h0777, 1'b0, ok);
        all_ok &= ok;
        tick();
        checks++;
        if ({bus.g_window_valid, bus.g_window_value} !== {1'b1, exp_yy}) begin
            errors++;
            $display("FAIL coincide_yy_issue got gv=%b px0=%h want 1 %h",
                     bus.g_window_valid, bus.g_window_value[14:0], exp_yy[14:0]);
        end
        serve(23'd13, 16'h0777, 1'b1, ok);
        all_ok &= ok;
        checks++;
        if ({all_ok, bus.out_valid, bus.out_value_yy} !== {1'b1, 1'b1, 23'd13}) begin
            errors++;
            $display("FAIL coincide_emit got ok=%b ov=%b yy=%0d want 1 1 13", all_ok, bus.out_valid, bus.out_value_yy);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int ov;
        do_reset();
        wait_req(ok);
        send_window(16'h0555);
        serve(23'd21, 16'h0555, 1'b1, ok);
        serve(23'd22, 16'h0555, 1'b1, ok);
        repeat (2) tick();
        checks++;
        if ({ok, bus.g_ready} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_setup got ok=%b rdy=%b want 1 1", ok, bus.g_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.window_req, bus.g_window_valid, bus.g_ready, bus.out_valid, bus.err, bus.err_code,
             bus.out_value_xx, bus.out_value_xy, bus.out_value_yy, bus.out_addr,
             bus.g_window_value, bus.g_window_addr} !== '0) begin
            errors++;
            $display("FAIL midreset_async got rdy=%b xx=%0d xy=%0d addr=%h want all zero",
                     bus.g_ready, bus.out_value_xx, bus.out_value_xy, bus.out_addr);
        end
        tick();
        rst_n = 1'b1;
        wait_req(ok);
        ov = int'(bus.out_valid);
        repeat (6) begin
            tick();
            ov += int'(bus.out_valid);
        end
        checks++;
        if ({ok, ov != 0} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_restart got req_seen=%b ov_cycles=%0d want 1 0", ok, ov);
        end
    endtask

    initial begin
        exp_xx = {25{1'b0, 14'h3FFF}};
        exp_xy = {25{15'h7FFB}};
        exp_yy = {25{1'b0, 14'h0123}};
        test_reset();
        test_nominal();
        test_stall();
        test_mismatch();
        test_timeout();
        test_stray();
        test_coincide();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
